// File: rtl/axi_rv_pkg.sv
// Shared response codes and FSM state encodings for the AXI-Lite to ready/valid bridge.
package axi_rv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

endpackage

// File: rtl/axi_to_ready_valid_n_timeout.sv
// Saturating stall counter; expire_c fires on the stall cycle that brings the count to LIMIT.
module rv_timeout_counter #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire_c
);

  generate
    if (LIMIT == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, en, clr};
      assign expire_c  = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(LIMIT + 1);
      logic [CW-1:0] cnt;

      // Count stall cycles, held at zero while cleared, saturating at LIMIT.
      always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
          cnt <= '0;
        end else if (en && (cnt != CW'(LIMIT))) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expire_c = en && (cnt == CW'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/axi_to_ready_valid_n.sv
// AXI4-Lite slave mapping one ready/valid user channel per 32-bit word, with DECERR and timeouts.
module axi_to_ready_valid_n
  import axi_rv_pkg::*;
#(
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_CH               = 8,
  parameter int unsigned TIMEOUT_CYCLES       = 1023
) (
  input  logic                                   S00_AXI_aclk,
  input  logic                                   S00_AXI_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        S00_AXI_awaddr,
  input  logic [2:0]                             S00_AXI_awprot,
  input  logic                                   S00_AXI_awvalid,
  output logic                                   S00_AXI_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]        S00_AXI_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]      S00_AXI_wstrb,
  input  logic                                   S00_AXI_wvalid,
  output logic                                   S00_AXI_wready,
  output logic [1:0]                             S00_AXI_bresp,
  output logic                                   S00_AXI_bvalid,
  input  logic                                   S00_AXI_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        S00_AXI_araddr,
  input  logic [2:0]                             S00_AXI_arprot,
  input  logic                                   S00_AXI_arvalid,
  output logic                                   S00_AXI_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]        S00_AXI_rdata,
  output logic [1:0]                             S00_AXI_rresp,
  output logic                                   S00_AXI_rvalid,
  input  logic                                   S00_AXI_rready,
  output logic [NUM_CH-1:0]                      ch_wvalid_o,
  input  logic [NUM_CH-1:0]                      ch_wready_i,
  input  logic [NUM_CH-1:0]                      ch_werror_i,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]        ch_wdata_o,
  output logic [C_S00_AXI_DATA_WIDTH/8-1:0]      ch_wstrb_o,
  output logic [NUM_CH-1:0]                      ch_rready_o,
  input  logic [NUM_CH-1:0]                      ch_rvalid_i,
  input  logic [NUM_CH*C_S00_AXI_DATA_WIDTH-1:0] ch_rdata_i,
  input  logic [NUM_CH-1:0]                      ch_rerror_i,
  output logic                                   wr_timeout_o,
  output logic                                   rd_timeout_o
);

  localparam int unsigned DW  = C_S00_AXI_DATA_WIDTH;
  localparam int unsigned AW  = C_S00_AXI_ADDR_WIDTH;
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic clk;
  logic rst_n;
  assign clk   = S00_AXI_aclk;
  assign rst_n = S00_AXI_aresetn;

  logic unused_ok;
  assign unused_ok = ^{S00_AXI_awprot, S00_AXI_arprot, S00_AXI_awaddr[1:0], S00_AXI_araddr[1:0]};

  // ---------------- write path ----------------
  w_state_t       w_state, w_state_d;
  logic [CHW-1:0] w_ch, w_ch_d;
  logic           w_unm, w_unm_d;
  logic [1:0]     bresp_q, bresp_d;
  logic           wr_to_q, wr_to_d;
  logic           w_stall_c, w_exp_c, wready_c;

  assign w_stall_c = (w_state == W_DATA) && !w_unm && S00_AXI_wvalid && !ch_wready_i[w_ch];
  assign wready_c  = (w_state == W_DATA) && (w_unm || ch_wready_i[w_ch] || w_exp_c);

  rv_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wr_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_stall_c),
    .clr      (w_state != W_DATA),
    .expire_c (w_exp_c)
  );

  // Write FSM next state and response selection.
  always_comb begin
    w_state_d = w_state;
    w_ch_d    = w_ch;
    w_unm_d   = w_unm;
    bresp_d   = bresp_q;
    wr_to_d   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (S00_AXI_awvalid) begin
          w_ch_d    = CHW'(S00_AXI_awaddr[AW-1:2]);
          w_unm_d   = 32'(S00_AXI_awaddr[AW-1:2]) >= NUM_CH;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S00_AXI_wvalid && wready_c) begin
          w_state_d = W_RESP;
          if (w_unm) begin
            bresp_d = RESP_DECERR;
          end else if (ch_wready_i[w_ch]) begin
            bresp_d = ch_werror_i[w_ch] ? RESP_SLVERR : RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
            wr_to_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (S00_AXI_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_ch    <= '0;
      w_unm   <= 1'b0;
      bresp_q <= RESP_OKAY;
      wr_to_q <= 1'b0;
    end else begin
      w_state <= w_state_d;
      w_ch    <= w_ch_d;
      w_unm   <= w_unm_d;
      bresp_q <= bresp_d;
      wr_to_q <= wr_to_d;
    end
  end

  assign S00_AXI_awready = rst_n && (w_state == W_IDLE);
  assign S00_AXI_wready  = rst_n && wready_c;
  assign S00_AXI_bvalid  = (w_state == W_RESP);
  assign S00_AXI_bresp   = bresp_q;
  assign wr_timeout_o    = wr_to_q;
  assign ch_wvalid_o     = (rst_n && (w_state == W_DATA) && !w_unm && !w_exp_c && S00_AXI_wvalid)
                           ? (NUM_CH'(1) << w_ch) : '0;
  assign ch_wdata_o      = (|ch_wvalid_o) ? S00_AXI_wdata : '0;
  assign ch_wstrb_o      = (|ch_wvalid_o) ? S00_AXI_wstrb : '0;

  // ---------------- read path ----------------
  r_state_t       r_state, r_state_d;
  logic [CHW-1:0] r_ch, r_ch_d;
  logic           r_unm, r_unm_d;
  logic [1:0]     rresp_q, rresp_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rd_to_q, rd_to_d;
  logic           r_stall_c, r_exp_c;

  assign r_stall_c = (r_state == R_WAIT) && !r_unm && !ch_rvalid_i[r_ch];

  rv_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_rd_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (r_stall_c),
    .clr      (r_state != R_WAIT),
    .expire_c (r_exp_c)
  );

  // Read FSM next state, data capture and response selection.
  always_comb begin
    r_state_d = r_state;
    r_ch_d    = r_ch;
    r_unm_d   = r_unm;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_to_d   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (S00_AXI_arvalid) begin
          r_ch_d    = CHW'(S00_AXI_araddr[AW-1:2]);
          r_unm_d   = 32'(S00_AXI_araddr[AW-1:2]) >= NUM_CH;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_unm) begin
          rdata_d   = '0;
          rresp_d   = RESP_DECERR;
          r_state_d = R_RESP;
        end else if (ch_rvalid_i[r_ch]) begin
          rdata_d   = ch_rdata_i[32'(r_ch)*DW +: DW];
          rresp_d   = ch_rerror_i[r_ch] ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_RESP;
        end else if (r_exp_c) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          rd_to_d   = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S00_AXI_rready) begin
          rdata_d   = '0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_ch    <= '0;
      r_unm   <= 1'b0;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
      rd_to_q <= 1'b0;
    end else begin
      r_state <= r_state_d;
      r_ch    <= r_ch_d;
      r_unm   <= r_unm_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      rd_to_q <= rd_to_d;
    end
  end

  assign S00_AXI_arready = rst_n && (r_state == R_IDLE);
  assign S00_AXI_rvalid  = (r_state == R_RESP);
  assign S00_AXI_rresp   = rresp_q;
  assign S00_AXI_rdata   = rdata_q;
  assign rd_timeout_o    = rd_to_q;
  assign ch_rready_o     = (rst_n && (r_state == R_WAIT) && !r_unm && !r_exp_c)
                           ? (NUM_CH'(1) << r_ch) : '0;

endmodule

// File: doc/axi_to_ready_valid_n.md
Name: axi_to_ready_valid_n

Overview:
AXI4-Lite slave that exposes NUM_CH independent ready/valid user channels, one per 32-bit word address (channel k at byte offset 4*k). It is the parametrised successor of the fixed 4-port bridge and adds three behaviours:
- write-strobe forwarding
- DECERR for unmapped addresses
- a per-transaction timeout that completes a hung access with SLVERR.
It sits between the PS/interconnect AXI-Lite master and PL user logic such as FIFOs, command ports and status sources.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, AXI and user data width (32 or 64).
C_S00_AXI_ADDR_WIDTH, 6, AXI address width; must be >= 2+clog2(NUM_CH).
NUM_CH, 8, number of user channels (1..16).
TIMEOUT_CYCLES, 1023, stall cycles before forced SLVERR completion; 0 disables timeout.

Ports:
S00_AXI_aclk  in  1  clock
S00_AXI_aresetn  in  1  synchronous reset, active low
S00_AXI_aw*/w*/b*/ar*/r*  -  per AXI4-Lite  standard slave channels (awprot/arprot ignored)
ch_wvalid_o  out  NUM_CH  one-hot write valid
ch_wready_i  in  NUM_CH  write ready per channel
ch_werror_i  in  NUM_CH  write error, sampled at write handshake
ch_wdata_o  out  DW  shared write data; 0 when no ch_wvalid_o bit is set
ch_wstrb_o  out  DW/8  shared write strobe; 0 when idle
ch_rready_o  out  NUM_CH  one-hot read ready
ch_rvalid_i  in  NUM_CH  read valid per channel
ch_rdata_i  in  NUM_CH*DW  read data, channel k at bits [k*DW +: DW]
ch_rerror_i  in  NUM_CH  read error, sampled at read handshake
wr_timeout_o  out  1  one-cycle pulse when a write times out
rd_timeout_o  out  1  one-cycle pulse when a read times out

Behaviour:
Reset (aresetn=0 at a clock edge):
- Both FSMs go to IDLE; bvalid=0, rvalid=0, bresp=rresp=0, rdata=0; timeout counters cleared; pulses 0.
- awready, arready, wready, ch_wvalid_o and ch_rready_o are gated low combinationally while aresetn=0.
- A user handshake pending when reset asserts is abandoned; no response is issued.

Index and response codes:
- idx = addr[ADDR_WIDTH-1:2]. If idx >= NUM_CH the access is unmapped.
- OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On awvalid: latch idx and the unmapped flag, go to W_DATA. The W beat is never accepted in W_IDLE.
- W_DATA, mapped: ch_wvalid_o[idx]=wvalid; ch_wdata_o=wdata; ch_wstrb_o=wstrb; wready=ch_wready_i[idx]. On wvalid&wready: bresp = ch_werror_i[idx] ? SLVERR : OKAY, go to W_RESP.
- W_DATA, unmapped: wready=1, no ch_wvalid_o. On wvalid: bresp=DECERR, go to W_RESP.
- Timeout: the counter increments on each W_DATA cycle with wvalid=1 and wready=0; it resets on entry to W_DATA. On the cycle the count equals TIMEOUT_CYCLES, wready is forced to 1 and ch_wvalid_o forced to 0, so the beat is consumed. Then bresp=SLVERR, wr_timeout_o pulses, and the FSM goes to W_RESP.
- W_RESP: bvalid=1. On bready: go to W_IDLE.
- Minimum write: AW, W and B in three consecutive cycles; the next AW can be accepted the cycle after the B handshake.

Read FSM (R_IDLE, R_WAIT, R_RESP):
- R_IDLE: arready=1. On arvalid: latch idx, go to R_WAIT.
- R_WAIT, mapped: ch_rready_o[idx]=1. On ch_rvalid_i[idx]: register rdata, rresp = error ? SLVERR : OKAY, go to R_RESP.
- R_WAIT, unmapped: after one cycle, rdata=0, rresp=DECERR, go to R_RESP.
- Timeout: the counter increments while ch_rvalid_i[idx]=0. At TIMEOUT_CYCLES: rdata=0, rresp=SLVERR, rd_timeout_o pulses, ch_rready_o drops, go to R_RESP.
- R_RESP: rvalid=1, with rdata/rresp stable until rready. On rready: clear rdata to 0, go to R_IDLE.

Concurrency and data rules:
- Read and write FSMs are fully independent and may target the same channel in the same cycle.
- Simultaneous handshake and timeout on the same cycle: the handshake wins and no pulse is issued.
- Counters are clog2(TIMEOUT_CYCLES+1) bits wide and saturate; with TIMEOUT_CYCLES=0 the counter logic is removed.
- No X is ever driven on outputs in synthesis.

Decomposition:
- Package axi_rv_pkg: response constants (RESP_OKAY, RESP_SLVERR, RESP_DECERR) and FSM state encodings.
- Sub-module rv_timeout_counter (enable, clear, expire pulse; parameter LIMIT), instantiated once per FSM.

Test Plan:
1. Write 0xDEADBEEF, wstrb 0xF, to addr 0x0C, ch_wready_i[3]=1 -> ch_wvalid_o=0b00001000 for 1 cycle, ch_wdata_o=0xDEADBEEF, bresp=OKAY, bvalid the cycle after the W handshake.
2. Read addr 0x14 with ch_rvalid_i[5] asserted 3 cycles late, ch_rdata_i[5]=0x12345678, ch_rerror_i[5]=1 -> rdata=0x12345678, rresp=SLVERR; ch_rready_o[5] high until the handshake.
3. NUM_CH=8: write 0x20 and read 0x3C -> no user strobes, bresp=DECERR, rresp=DECERR, rdata=0.
4. TIMEOUT_CYCLES=4, write to channel 1 with ch_wready_i=0 -> W beat consumed on the 4th stall cycle, wr_timeout_o pulses once, bresp=SLVERR; a following write to channel 2 completes OKAY.
5. Concurrent write to ch0 and read from ch0 in the same cycle, bready/rready held low 5 cycles -> both responses held stable, awready=arready=0 until the respective B/R handshake.
6. aresetn=0 for 1 cycle while in W_DATA and R_WAIT -> ch_wvalid_o/ch_rready_o low immediately, bvalid=rvalid=0 after the edge, awready=arready=1 the next cycle.
